ps2_command_out: RTL and testbench

- Host-to-device PS/2 transmitter: the sending side paired with the existing PS/2 receive path.
- Sends one 8-bit command byte (e.g. 0xED keyboard-LED set, 0xF4 enable, 0xFF reset) to the keyboard, following the PS/2 request-to-send protocol, including the device ACK.
- Drives PS2_CLK/PS2_DAT open-drain through output-enable ports. The top level builds the tristates (line = oe ? 0 : z) and feeds the pad values back as inputs.

---
 rtl/ps2_command_out.sv | 174 +++++++++++++++++
 tb/tb_ps2_command_out.sv | 234 +++++++++++++++++++++++
 2 files changed

// File: rtl/ps2_command_out.sv
// rtl/ps2_command_out.sv - PS/2 host-to-device command transmitter with open-drain output enables.
// Optional timeouts are built when PS2_COMMAND_OUT_TIMEOUT_EN is defined.
module ps2_command_out #(
  parameter int INHIBIT_CYCLES = 5000,
  parameter int START_TIMEOUT  = 750000,
  parameter int PACKET_TIMEOUT = 100000
) (
  input  logic       iCLK,
  input  logic       iRST_N,
  input  logic [7:0] the_command,
  input  logic       send_command,
  input  logic       ps2_clk_in,
  input  logic       ps2_dat_in,
  output logic       ps2_clk_oe,
  output logic       ps2_dat_oe,
  output logic       busy,
  output logic       command_was_sent,
  output logic       error_communication_timed_out
);

  localparam int MAX_AB = (INHIBIT_CYCLES > START_TIMEOUT) ? INHIBIT_CYCLES : START_TIMEOUT;
  localparam int MAX_P  = (MAX_AB > PACKET_TIMEOUT) ? MAX_AB : PACKET_TIMEOUT;
  localparam int CW     = $clog2(MAX_P) + 1;

  typedef enum logic [2:0] {
    S_IDLE, S_INHIBIT, S_RELEASE, S_SHIFT, S_ACK, S_WAIT_IDLE
  } state_t;

  state_t          state, state_d;
  logic [1:0]      clk_sync, dat_sync;
  logic            clk_prev;
  logic            clk_s, dat_s, fe;
  logic [8:0]      shreg, shreg_d;
  logic [3:0]      bit_cnt, bit_cnt_d;
  logic [CW-1:0]   inh_cnt, inh_cnt_d;
  logic            clk_oe_d, dat_oe_d, sent_d;

  assign clk_s = clk_sync[1];
  assign dat_s = dat_sync[1];
  assign fe    = clk_prev & ~clk_s;
  assign busy  = (state != S_IDLE);

`ifdef PS2_COMMAND_OUT_TIMEOUT_EN
  logic [CW-1:0]   to_cnt, to_cnt_d, to_limit;
  logic            err_d;
`else
  assign error_communication_timed_out = 1'b0;
`endif

  always_ff @(posedge iCLK or negedge iRST_N) begin
    if (!iRST_N) begin
      state            <= S_IDLE;
      clk_sync         <= 2'b00;
      dat_sync         <= 2'b00;
      clk_prev         <= 1'b0;
      shreg            <= '0;
      bit_cnt          <= '0;
      inh_cnt          <= '0;
      ps2_clk_oe       <= 1'b0;
      ps2_dat_oe       <= 1'b0;
      command_was_sent <= 1'b0;
`ifdef PS2_COMMAND_OUT_TIMEOUT_EN
      to_cnt                        <= '0;
      error_communication_timed_out <= 1'b0;
`endif
    end else begin
      state            <= state_d;
      clk_sync         <= {clk_sync[0], ps2_clk_in};
      dat_sync         <= {dat_sync[0], ps2_dat_in};
      clk_prev         <= clk_s;
      shreg            <= shreg_d;
      bit_cnt          <= bit_cnt_d;
      inh_cnt          <= inh_cnt_d;
      ps2_clk_oe       <= clk_oe_d;
      ps2_dat_oe       <= dat_oe_d;
      command_was_sent <= sent_d;
`ifdef PS2_COMMAND_OUT_TIMEOUT_EN
      to_cnt                        <= to_cnt_d;
      error_communication_timed_out <= err_d;
`endif
    end
  end

  always_comb begin
    state_d   = state;
    shreg_d   = shreg;
    bit_cnt_d = bit_cnt;
    inh_cnt_d = inh_cnt;
    clk_oe_d  = ps2_clk_oe;
    dat_oe_d  = ps2_dat_oe;
    sent_d    = 1'b0;
`ifdef PS2_COMMAND_OUT_TIMEOUT_EN
    to_cnt_d  = to_cnt;
    err_d     = 1'b0;
    to_limit  = (state == S_RELEASE) ? CW'(START_TIMEOUT - 1) : CW'(PACKET_TIMEOUT - 1);
`endif
    case (state)
      S_IDLE: begin
        clk_oe_d = 1'b0;
        dat_oe_d = 1'b0;
        if (send_command) begin
          shreg_d   = {~^the_command, the_command};
          inh_cnt_d = '0;
          bit_cnt_d = '0;
          clk_oe_d  = 1'b1;
          state_d   = S_INHIBIT;
`ifdef PS2_COMMAND_OUT_TIMEOUT_EN
          to_cnt_d  = '0;
`endif
        end
      end
      S_INHIBIT: begin
        // Start bit goes low one cycle before the clock is released.
        if (inh_cnt == CW'(INHIBIT_CYCLES - 1)) begin
          clk_oe_d = 1'b0;
          state_d  = S_RELEASE;
        end else begin
          inh_cnt_d = inh_cnt + 1'b1;
          if (inh_cnt == CW'(INHIBIT_CYCLES - 2)) dat_oe_d = 1'b1;
        end
      end
      S_RELEASE: begin
        if (fe) begin
          dat_oe_d  = ~shreg[0];
          shreg_d   = {1'b0, shreg[8:1]};
          bit_cnt_d = 4'd1;
          state_d   = S_SHIFT;
`ifdef PS2_COMMAND_OUT_TIMEOUT_EN
          to_cnt_d  = CW'(1);
`endif
        end
      end
      S_SHIFT: begin
        if (fe) begin
          if (bit_cnt == 4'd9) begin
            dat_oe_d = 1'b0;
            state_d  = S_ACK;
          end else begin
            dat_oe_d  = ~shreg[0];
            shreg_d   = {1'b0, shreg[8:1]};
            bit_cnt_d = bit_cnt + 1'b1;
          end
        end
      end
      S_ACK: begin
        // bit_cnt==10 marks that fe 11 passed with data high; keep waiting for it to drop.
        if ((fe || bit_cnt == 4'd10) && !dat_s) state_d = S_WAIT_IDLE;
        else if (fe)                            bit_cnt_d = 4'd10;
      end
      S_WAIT_IDLE: begin
        if (clk_s && dat_s) begin
          sent_d  = 1'b1;
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
`ifdef PS2_COMMAND_OUT_TIMEOUT_EN
    // Completion in the same cycle wins over a timeout.
    if (state != S_IDLE && state != S_INHIBIT && !(state == S_RELEASE && fe)
        && state_d != S_IDLE) begin
      if (to_cnt == to_limit) begin
        state_d  = S_IDLE;
        clk_oe_d = 1'b0;
        dat_oe_d = 1'b0;
        err_d    = 1'b1;
      end else begin
        to_cnt_d = to_cnt + 1'b1;
      end
    end
`endif
  end

endmodule

// File: tb/tb_ps2_command_out.sv
// tb/tb_ps2_command_out.sv - directed and random command transfers against a PS/2 device model.
module tb_ps2_command_out;

  localparam int INH = 50;
  localparam int ST  = 2000;
  localparam int PT  = 4000;

  logic       iCLK = 1'b0;
  logic       iRST_N = 1'b0;
  logic [7:0] the_command = 8'h00;
  logic       send_command = 1'b0;
  logic       dev_clk = 1'b1;
  logic       dev_dat = 1'b1;
  logic       ps2_clk_in, ps2_dat_in;
  logic       ps2_clk_oe, ps2_dat_oe, busy, command_was_sent, error_communication_timed_out;

  assign ps2_clk_in = dev_clk & ~ps2_clk_oe;
  assign ps2_dat_in = dev_dat & ~ps2_dat_oe;

  ps2_command_out #(
    .INHIBIT_CYCLES(INH), .START_TIMEOUT(ST), .PACKET_TIMEOUT(PT)
  ) dut (
    .iCLK(iCLK), .iRST_N(iRST_N), .the_command(the_command), .send_command(send_command),
    .ps2_clk_in(ps2_clk_in), .ps2_dat_in(ps2_dat_in),
    .ps2_clk_oe(ps2_clk_oe), .ps2_dat_oe(ps2_dat_oe), .busy(busy),
    .command_was_sent(command_was_sent),
    .error_communication_timed_out(error_communication_timed_out)
  );

  always #5 iCLK = ~iCLK;

  int cyc = 0;
  int succ_cnt = 0, err_cnt = 0, err_cyc = 0;
  int n_vec = 0, n_fail = 0;

  always @(posedge iCLK) cyc <= cyc + 1;

  always @(negedge iCLK) begin
    if (command_was_sent) succ_cnt++;
    if (error_communication_timed_out) begin
      err_cnt++;
      err_cyc = cyc;
    end
  end

  initial begin
    #5000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick;
    @(posedge iCLK);
    #1;
  endtask

  // Frame as the device sees it: start 0, data LSB first, odd parity, stop 1.
  function automatic logic [10:0] frame(input logic [7:0] c);
    logic par;
    par = ($countones(c) % 2 == 0);
    return {1'b1, par, c, 1'b0};
  endfunction

  task automatic start_cmd(input logic [7:0] c);
    the_command  = c;
    send_command = 1'b1;
    tick;
    send_command = 1'b0;
    chk("busy_rise", busy, 1);
  endtask

  task automatic measure_inhibit(output int r);
    int n;
    n = 0;
    while (ps2_clk_oe && n < 1000) begin
      n++;
      tick;
    end
    chk("inhibit_len", n, INH);
    chk("start_bit_drive", ps2_dat_oe, 1);
    r = cyc;
  endtask

  // mode 0: ACK, 1: withhold ACK, 2: reset at fe 5, 3: extra request during transfer
  task automatic device_clock(input int mode, output logic [10:0] bits, output int k);
    bits = '0;
    k = 0;
    repeat (30) tick;
    bits[0] = ps2_dat_in;
    for (int i = 1; i <= 11; i++) begin
      if (i == 11 && mode != 1) dev_dat = 1'b0;
      dev_clk = 1'b0;
      if (i == 1) k = cyc;
      if (mode == 2 && i == 5) begin
        chk("pre_rst_busy", busy, 1);
        chk("pre_rst_dat_oe", ps2_dat_oe, 1);
        iRST_N = 1'b0;
        #1;
        chk("rst_clk_oe", ps2_clk_oe, 0);
        chk("rst_dat_oe", ps2_dat_oe, 0);
        chk("rst_busy", busy, 0);
        chk("rst_sent", command_was_sent, 0);
        chk("rst_err", error_communication_timed_out, 0);
        return;
      end
      if (mode == 3 && i == 3) begin
        the_command  = 8'h00;
        send_command = 1'b1;
        tick;
        send_command = 1'b0;
        repeat (39) tick;
      end else begin
        repeat (40) tick;
      end
      dev_clk = 1'b1;
      if (i <= 10) bits[i] = ps2_dat_in;
      repeat (40) tick;
    end
    dev_dat = 1'b1;
  endtask

  task automatic xfer(input logic [7:0] c, input int mode);
    int s0, e0, r, k, n;
    logic [10:0] bits;
    s0 = succ_cnt;
    e0 = err_cnt;
    start_cmd(c);
    measure_inhibit(r);
    device_clock(mode, bits, k);
    n = 0;
    while (succ_cnt == s0 && n < 500) begin
      n++;
      tick;
    end
    repeat (10) tick;
    chk("frame", bits, frame(c));
    chk("success_pulses", succ_cnt - s0, 1);
    chk("busy_after", busy, 0);
    chk("no_error", err_cnt - e0, 0);
    chk("oe_idle", {ps2_clk_oe, ps2_dat_oe}, 0);
  endtask

  initial begin
    int s0, e0, r, k, n;
    logic [10:0] bits;
    repeat (3) tick;
    chk("reset_outputs", {ps2_clk_oe, ps2_dat_oe, busy, command_was_sent,
                          error_communication_timed_out}, 0);
    iRST_N = 1'b1;
    tick;

    xfer(8'hED, 0);
    xfer(8'hF4, 0);
    xfer(8'hED, 3);
    for (int i = 0; i < 4; i++) xfer(8'($urandom_range(0, 255)), 0);

    // Reset in the middle of a transfer, then recover with 0xFF.
    start_cmd(8'h00);
    measure_inhibit(r);
    device_clock(2, bits, k);
    dev_clk = 1'b1;
    dev_dat = 1'b1;
    repeat (3) tick;
    iRST_N = 1'b1;
    tick;
    xfer(8'hFF, 0);

`ifdef PS2_COMMAND_OUT_TIMEOUT_EN
    // No device clock after release.
    s0 = succ_cnt;
    e0 = err_cnt;
    start_cmd(8'hF4);
    measure_inhibit(r);
    n = 0;
    while (err_cnt == e0 && n < 3000) begin
      n++;
      tick;
    end
    chk("start_timeout_pulses", err_cnt - e0, 1);
    chk("start_timeout_delay", err_cyc - r, ST);
    repeat (2) tick;
    chk("start_timeout_oe", {ps2_clk_oe, ps2_dat_oe}, 0);
    chk("start_timeout_busy", busy, 0);
    chk("start_timeout_no_success", succ_cnt - s0, 0);

    // Device withholds ACK; fe 1 is seen two sync stages plus one edge after the pad falls.
    s0 = succ_cnt;
    e0 = err_cnt;
    start_cmd(8'hED);
    measure_inhibit(r);
    device_clock(1, bits, k);
    n = 0;
    while (err_cnt == e0 && n < 5000) begin
      n++;
      tick;
    end
    repeat (5) tick;
    chk("nack_frame", bits, frame(8'hED));
    chk("nack_timeout_pulses", err_cnt - e0, 1);
    chk("nack_timeout_delay", err_cyc - k, PT + 2);
    chk("nack_no_success", succ_cnt - s0, 0);
    chk("nack_busy", busy, 0);
    chk("nack_oe", {ps2_clk_oe, ps2_dat_oe}, 0);
`else
    // Without timeouts a silent device leaves the transfer waiting until reset.
    e0 = err_cnt;
    start_cmd(8'hF4);
    measure_inhibit(r);
    repeat (3000) tick;
    chk("stuck_busy", busy, 1);
    chk("stuck_dat_oe", ps2_dat_oe, 1);
    chk("stuck_no_error", err_cnt - e0, 0);
    iRST_N = 1'b0;
    tick;
    iRST_N = 1'b1;
    tick;
    chk("stuck_reset_busy", busy, 0);
`endif

    xfer(8'($urandom_range(0, 255)), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
